// File: rtl/tlc_pkg.sv
// tlc_pkg: light codes, FSM state encoding and lamp helper functions shared by the phase sequencer.
package tlc_pkg;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] AMBER = 3'b010;
   localparam logic [2:0] GREEN = 3'b001;
   localparam logic [2:0] DARK  = 3'b000;
   localparam int MAX_DIR = 64;
   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, FLASH = 2'd3} state_t;
   function automatic logic [3*MAX_DIR-1:0] all_red(int n);
      all_red = '0;
      for (int d = 0; d < n && d < MAX_DIR; d++) all_red[3*d +: 3] = RED;
   endfunction
   // Anything but a single lit lamp is forced to red so a corrupt table can never show green.
   function automatic logic [2:0] sanitize(logic [2:0] c);
      return (c == RED || c == AMBER || c == GREEN) ? c : RED;
   endfunction
endpackage

// File: rtl/tlc_phase_sequencer_if.sv
// tlc_phase_sequencer_if: supervisor-side control/config bus and lamp-side outputs of the sequencer.
interface tlc_phase_sequencer_if #(
   parameter int NUM_DIR    = 4,
   parameter int NUM_PHASES = 6,
   parameter int CNT_W      = 8
);
   localparam int PH_W = $clog2(NUM_PHASES);
   logic                 run;
   logic                 flash;
   logic                 cfg_we;
   logic [PH_W-1:0]      cfg_addr;
   logic [CNT_W-1:0]     cfg_dur;
   logic [3*NUM_DIR-1:0] cfg_pat;
   logic [3*NUM_DIR-1:0] lights;
   logic [PH_W-1:0]      phase_idx;
   logic                 phase_done;
   logic [1:0]           state_o;
   modport master (output run, flash, cfg_we, cfg_addr, cfg_dur, cfg_pat,
                   input lights, phase_idx, phase_done, state_o);
   modport slave (input run, flash, cfg_we, cfg_addr, cfg_dur, cfg_pat,
                  output lights, phase_idx, phase_done, state_o);
endinterface

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: free-running prescaler; tick is high one clk in every TICK_DIV, first one TICK_DIV cycles after reset.
module tlc_tick_gen #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV) + 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(TICK_DIV - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tlc_phase_sequencer.sv
// tlc_phase_sequencer: programmable phase table plus IDLE/CLEAR/RUN/FLASH sequencer driving registered lamp codes.
module tlc_phase_sequencer
   import tlc_pkg::*;
#(
   parameter int NUM_DIR    = 4,
   parameter int NUM_PHASES = 6,
   parameter int CNT_W      = 8,
   parameter int TICK_DIV   = 1,
   parameter int ALLRED_T   = 2,
   parameter int FLASH_T    = 1
) (
   input logic clk,
   input logic rst,
   tlc_phase_sequencer_if.slave bus
);
   localparam int PH_W = $clog2(NUM_PHASES);
   localparam int LW = 3 * NUM_DIR;
   localparam logic [LW-1:0] ALL_RED = LW'(all_red(NUM_DIR));
   localparam logic [LW-1:0] ALL_AMBER = {NUM_DIR{AMBER}};
   logic [CNT_W-1:0] tdur [NUM_PHASES];
   logic [LW-1:0]    tpat [NUM_PHASES];
   state_t           state;
   logic [CNT_W-1:0] cnt, sh_dur;
   logic [PH_W-1:0]  nxt;
   logic [LW-1:0]    nxt_pat, pat0;
   logic             tick;
   tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
   assign bus.state_o = state;
   always_comb begin
      nxt = (bus.phase_idx == PH_W'(NUM_PHASES - 1)) ? '0 : bus.phase_idx + 1'b1;
      nxt_pat = '0;
      pat0 = '0;
      for (int d = 0; d < NUM_DIR; d++) begin
         nxt_pat[3*d +: 3] = sanitize(tpat[nxt][3*d +: 3]);
         pat0[3*d +: 3] = sanitize(tpat[0][3*d +: 3]);
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int p = 0; p < NUM_PHASES; p++) begin
            tdur[p] <= '0;
            tpat[p] <= ALL_RED;
         end
      end else if (bus.cfg_we && 32'(bus.cfg_addr) < NUM_PHASES) begin
         tdur[bus.cfg_addr] <= bus.cfg_dur;
         tpat[bus.cfg_addr] <= bus.cfg_pat;
      end
   // The lights register doubles as the shadow pattern; sh_dur shadows the dwell.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         bus.lights <= ALL_RED;
         bus.phase_idx <= '0;
         bus.phase_done <= 1'b0;
         cnt <= '0;
         sh_dur <= '0;
      end else begin
         bus.phase_done <= 1'b0;
         case (state)
            IDLE: if (bus.run || bus.flash) begin
               state <= CLEAR;
               cnt <= '0;
            end
            CLEAR: if (tick) begin
               if (cnt == CNT_W'(ALLRED_T - 1)) begin
                  cnt <= '0;
                  if (bus.flash) begin
                     state <= FLASH;
                     bus.lights <= ALL_AMBER;
                  end else if (bus.run) begin
                     state <= RUN;
                     bus.phase_idx <= '0;
                     sh_dur <= tdur[0];
                     bus.lights <= pat0;
                  end else state <= IDLE;
               end else cnt <= cnt + 1'b1;
            end
            RUN: if (tick) begin
               if (cnt == sh_dur) begin
                  cnt <= '0;
                  bus.phase_done <= 1'b1;
                  if (bus.flash || !bus.run) begin
                     state <= CLEAR;
                     bus.phase_idx <= '0;
                     bus.lights <= ALL_RED;
                  end else begin
                     bus.phase_idx <= nxt;
                     sh_dur <= tdur[nxt];
                     bus.lights <= nxt_pat;
                  end
               end else cnt <= cnt + 1'b1;
            end
            FLASH: if (!bus.flash) begin
               state <= CLEAR;
               cnt <= '0;
               bus.lights <= ALL_RED;
            end else if (tick) begin
               if (cnt == CNT_W'(FLASH_T - 1)) begin
                  cnt <= '0;
                  bus.lights <= (bus.lights == ALL_AMBER) ? '0 : ALL_AMBER;
               end else cnt <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// tb_tlc_phase_sequencer: two sequencers (TICK_DIV 1 and 4) under shared random stimulus, checked against a
// segment-level model that counts remaining ticks per IDLE/CLEAR/RUN/FLASH interval.
module tb_tlc_phase_sequencer;
   localparam logic [11:0] ALL_RED = 12'o4444;
   localparam logic [11:0] ALL_AMB = 12'o2222;
   localparam logic [17:0] RST_V = {ALL_RED, 3'd0, 1'b0, 2'd0};
   logic clk = 1'b0, rst = 1'b1;
   logic run = 1'b0, flash = 1'b0, cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [7:0] cfg_dur = '0;
   logic [11:0] cfg_pat = '0;
   int n_chk = 0, n_fail = 0;
   int td[2], ar[2], ft[2];
   int mode[2], rem[2], ph[2], k[2];
   logic done_m[2], amb[2];
   logic [11:0] shp[2];
   int tdur[6];
   logic [11:0] tpat[6];
   tlc_phase_sequencer_if #(.NUM_DIR(4), .NUM_PHASES(6), .CNT_W(8)) b0 ();
   tlc_phase_sequencer_if #(.NUM_DIR(4), .NUM_PHASES(6), .CNT_W(8)) b1 ();
   assign b0.run = run;
   assign b0.flash = flash;
   assign b0.cfg_we = cfg_we;
   assign b0.cfg_addr = cfg_addr;
   assign b0.cfg_dur = cfg_dur;
   assign b0.cfg_pat = cfg_pat;
   assign b1.run = run;
   assign b1.flash = flash;
   assign b1.cfg_we = cfg_we;
   assign b1.cfg_addr = cfg_addr;
   assign b1.cfg_dur = cfg_dur;
   assign b1.cfg_pat = cfg_pat;
   tlc_phase_sequencer #(.NUM_DIR(4), .NUM_PHASES(6), .CNT_W(8), .TICK_DIV(1), .ALLRED_T(2), .FLASH_T(1))
      dut0 (.clk(clk), .rst(rst), .bus(b0));
   tlc_phase_sequencer #(.NUM_DIR(4), .NUM_PHASES(6), .CNT_W(8), .TICK_DIV(4), .ALLRED_T(3), .FLASH_T(2))
      dut1 (.clk(clk), .rst(rst), .bus(b1));
   always #5 clk = ~clk;

   function automatic logic [11:0] safe(logic [11:0] p);
      logic [2:0] c;
      safe = '0;
      for (int d = 0; d < 4; d++) begin
         c = p[3*d +: 3];
         safe[3*d +: 3] = ($countones(c) == 1) ? c : 3'b100;
      end
   endfunction
   function automatic logic [17:0] expv(int m);
      logic [11:0] l;
      l = mode[m] == 2 ? safe(shp[m]) : mode[m] == 3 ? (amb[m] ? ALL_AMB : 12'o0000) : ALL_RED;
      return {l, mode[m] == 2 ? 3'(ph[m]) : 3'd0, done_m[m], 2'(mode[m])};
   endfunction
   function automatic logic [17:0] obs(int m);
      return m == 1 ? {b1.lights, b1.phase_idx, b1.phase_done, b1.state_o}
                    : {b0.lights, b0.phase_idx, b0.phase_done, b0.state_o};
   endfunction
   function automatic logic [11:0] rand_pat();
      for (int d = 0; d < 4; d++) rand_pat[3*d +: 3] = 3'b001 << $urandom_range(0, 2);
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mode[m] = 0; rem[m] = 0; ph[m] = 0; k[m] = 0;
         done_m[m] = 1'b0; amb[m] = 1'b0; shp[m] = ALL_RED;
      end
      for (int p = 0; p < 6; p++) begin
         tdur[p] = 0;
         tpat[p] = ALL_RED;
      end
   endtask
   task automatic enter(int m, int p);
      mode[m] = 2; ph[m] = p; rem[m] = tdur[p] + 1; shp[m] = tpat[p];
   endtask
   task automatic model_edge();
      bit tk;
      for (int m = 0; m < 2; m++) begin
         k[m]++;
         tk = (k[m] % td[m]) == 0;
         done_m[m] = 1'b0;
         case (mode[m])
            0: if (run || flash) begin mode[m] = 1; rem[m] = ar[m]; end
            1: if (tk) begin
               rem[m]--;
               if (rem[m] == 0) begin
                  if (flash) begin mode[m] = 3; amb[m] = 1'b1; rem[m] = ft[m]; end
                  else if (run) enter(m, 0);
                  else mode[m] = 0;
               end
            end
            2: if (tk) begin
               rem[m]--;
               if (rem[m] == 0) begin
                  done_m[m] = 1'b1;
                  if (flash || !run) begin mode[m] = 1; rem[m] = ar[m]; end
                  else enter(m, (ph[m] + 1) % 6);
               end
            end
            default: if (!flash) begin mode[m] = 1; rem[m] = ar[m]; end
               else if (tk) begin
                  rem[m]--;
                  if (rem[m] == 0) begin amb[m] = !amb[m]; rem[m] = ft[m]; end
               end
         endcase
      end
      if (cfg_we && cfg_addr < 3'd6) begin
         tdur[cfg_addr] = int'(cfg_dur);
         tpat[cfg_addr] = cfg_pat;
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; flash = 1'b0;
      #23;
      for (int m = 0; m < 2; m++) begin
         n_chk++;
         if (obs(m) !== RST_V) begin n_fail++; $display("FAIL reset dut%0d got %h want %h", m, obs(m), RST_V); end
      end
      @(negedge clk) rst = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL reset_idle dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
   endtask

   task automatic test_program_run();
      int durs[6] = '{7, 2, 5, 5, 3, 2};
      int c0 = 0, cd = 0;
      for (int p = 0; p < 6; p++) begin
         cfg_we = 1'b1; cfg_addr = 3'(p); cfg_dur = 8'(durs[p]); cfg_pat = rand_pat();
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL program dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      cfg_we = 1'b0; run = 1'b1;
      for (int i = 0; i < 72; i++) begin
         step();
         if (i < 32 && b0.state_o == 2'd2 && b0.phase_idx == 3'd0) c0++;
         if (i < 32 && b0.phase_done) cd++;
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL run_seq dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      n_chk++;
      if (c0 !== 8) begin n_fail++; $display("FAIL phase0_len got %0d want 8", c0); end
      n_chk++;
      if (cd !== 5) begin n_fail++; $display("FAIL done_count got %0d want 5", cd); end
   endtask

   task automatic test_write_active();
      int t = 0;
      while (!(mode[0] == 2 && ph[0] == 2) && t < 200) begin
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL wr_wait dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
         t++;
      end
      n_chk++;
      if (t >= 200) begin n_fail++; $display("FAIL wr_wait_timeout cycles %0d limit 200", t); end
      for (int i = 0; i < 84; i++) begin
         cfg_we = i < 2;
         cfg_addr = i == 0 ? 3'd2 : 3'd7;
         cfg_dur = i == 0 ? 8'd9 : 8'd0;
         cfg_pat = i == 0 ? rand_pat() : 12'o0000;
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL write_active dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_sanitize();
      int t = 0;
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_dur = 8'd2; cfg_pat = {3'b010, 3'b010, 3'b011, 3'b001};
      step();
      cfg_we = 1'b0;
      while (!(mode[0] == 2 && ph[0] == 3 && shp[0] == 12'o2231) && t < 200) begin
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL san_wait dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
         t++;
      end
      n_chk++;
      if (b0.lights !== 12'o2241) begin n_fail++; $display("FAIL sanitize got %o want 2241 (t=%0d)", b0.lights, t); end
   endtask

   task automatic test_flash();
      int t = 0, na = 0, nd = 0;
      while (!(mode[0] == 2 && rem[0] > 2) && t < 200) begin step(); t++; end
      n_chk++;
      if (t >= 200) begin n_fail++; $display("FAIL flash_wait_timeout cycles %0d limit 200", t); end
      flash = 1'b1;
      for (int i = 0; i < 70; i++) begin
         step();
         if (b0.lights === ALL_AMB) na++;
         if (b0.lights === 12'o0000) nd++;
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL flash dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      n_chk++;
      if (na == 0 || nd == 0) begin n_fail++; $display("FAIL flash_toggle amber %0d dark %0d want both nonzero", na, nd); end
      flash = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL unflash dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
   endtask

   task automatic test_run_stop();
      run = 1'b0;
      for (int i = 0; i < 90; i++) begin
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL run_stop dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      for (int m = 0; m < 2; m++) begin
         n_chk++;
         if (obs(m) !== RST_V) begin n_fail++; $display("FAIL stop_idle dut%0d got %h want %h", m, obs(m), RST_V); end
      end
   endtask

   task automatic test_tick_div();
      int pt[$];
      for (int p = 0; p < 6; p++) begin
         cfg_we = 1'b1; cfg_addr = 3'(p); cfg_dur = 8'd1; cfg_pat = rand_pat();
         step();
      end
      cfg_we = 1'b0; run = 1'b1;
      for (int i = 0; i < 120; i++) begin
         step();
         if (b1.phase_done) pt.push_back(i);
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL tick_div dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      n_chk++;
      if (pt.size() < 3 || pt[2] - pt[1] != 8) begin n_fail++; $display("FAIL div4_phase_len pulses %0d gap %0d want 8", pt.size(), pt.size() < 3 ? -1 : pt[2] - pt[1]); end
   endtask

   task automatic test_reset_mid_run();
      int t = 0;
      while (mode[0] != 2 && t < 100) begin step(); t++; end
      #2 rst = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         n_chk++;
         if (obs(m) !== RST_V) begin n_fail++; $display("FAIL reset_mid dut%0d got %h want %h", m, obs(m), RST_V); end
      end
      model_reset();
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL after_reset dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) run = !run;
         if ($urandom_range(0, 59) == 0) flash = !flash;
         cfg_we = $urandom_range(0, 7) == 0;
         cfg_addr = 3'($urandom_range(0, 7));
         cfg_dur = 8'($urandom_range(0, 3));
         cfg_pat = 12'($urandom);
         step();
         for (int m = 0; m < 2; m++) begin
            n_chk++;
            if (obs(m) !== expv(m)) begin n_fail++; $display("FAIL random dut%0d t=%0t got %h want %h", m, $time, obs(m), expv(m)); end
         end
      end
      cfg_we = 1'b0;
   endtask

   initial begin
      td[0] = 1; ar[0] = 2; ft[0] = 1;
      td[1] = 4; ar[1] = 3; ft[1] = 2;
      model_reset();
      test_reset();
      test_program_run();
      test_write_active();
      test_sanitize();
      test_flash();
      test_run_stop();
      test_tick_div();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tlc_phase_sequencer.md
# tlc_phase_sequencer

Parametrised, run-time-programmable traffic-light phase sequencer for intersections with any number of approaches and phases. It replaces fixed six-phase, hard-coded-duration controllers. It adds a configuration write port for the per-phase dwell time and light pattern, an all-red clearance interval, a run/stop control, and a night flashing-amber mode. It sits between the intersection supervisor (config and mode inputs) and the lamp drivers (registered light outputs).

## Interface
- NUM_DIR, 4, number of approaches; each approach has one 3-bit light code.
- NUM_PHASES, 6, phases in the cycle (2..16).
- CNT_W, 8, width of the dwell and clearance counters.
- TICK_DIV, 1, clk cycles per timing tick (1 means every cycle is a tick).
- ALLRED_T, 2, clearance length in ticks.
- FLASH_T, 1, ticks per flash half-period.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 means cycle phases, 0 means stop at all-red.
- flash  in  1  level; 1 means night flashing-amber mode (has priority over run).
- cfg_we  in  1  write strobe for the phase table.
- cfg_addr  in  PH_W=$clog2(NUM_PHASES)  phase index.
- cfg_dur  in  CNT_W  dwell value; the phase lasts cfg_dur+1 ticks.
- cfg_pat  in  3*NUM_DIR  light codes, with approach d at bits [3d+2:3d].
- lights  out  3*NUM_DIR  registered light codes: 100 red, 010 amber, 001 green, 000 dark.
- phase_idx  out  PH_W  active phase; 0 outside RUN.
- phase_done  out  1  one-cycle pulse when a RUN phase ends.
- state_o  out  2  current FSM state.

## Operation
- Phase table:
  - NUM_PHASES entries of {dur, pat}.
  - Reset value of every entry is dur=0 with all approaches red.
  - A write with cfg_addr ≥ NUM_PHASES is ignored.
- At phase entry, the active dur/pat is copied into shadow registers. Later writes to the active entry take effect only on its next entry. A write in the same cycle as entry to that phase gives the old value.
- Safety rule: any pattern field that is not one-hot (including 000) is driven as red.
- FSM states: IDLE=0, CLEAR=1, RUN=2, FLASH=3.
  - IDLE: all lights red. If flash=1, go to CLEAR. If run=1, go to CLEAR.
  - CLEAR: all lights red for ALLRED_T ticks. Then:
    - flash=1 → FLASH.
    - run=1 → RUN at phase 0.
    - otherwise → IDLE.
  - RUN:
    - lights = shadow pat.
    - The counter increments on each tick. On the tick where count==dur: pulse phase_done, clear the count, and advance phase (NUM_PHASES-1 wraps to 0).
    - At a phase end with flash=1 or run=0, go to CLEAR instead of advancing.
    - A mid-phase flash or run change never truncates a phase.
  - FLASH: every approach alternates amber/dark, starting amber, toggling every FLASH_T ticks. When flash=0, go to CLEAR.
- Reset: state IDLE, lights all red (100 on every approach), phase_idx 0, phase_done 0, counters and prescaler 0, table at its reset values. Reset mid-phase aborts immediately.

## Timing
- Tick: the prescaler asserts tick for one clk every TICK_DIV cycles. The first tick comes TICK_DIV cycles after reset release.
- Every output is registered and reflects the state/phase decided at the previous clock edge.
- IDLE→CLEAR is taken on the first clk edge where run or flash is sampled high; it does not wait for a tick.
- CLEAR, RUN dwell and FLASH timers advance only on ticks.
- Phase length is exactly (dur+1)*TICK_DIV clk cycles. dur=0 gives a one-tick phase.
- phase_done is asserted in the same cycle that phase_idx/lights switch to the next phase or to CLEAR.
- Counters are CNT_W bits and never wrap within a phase, because the dwell compare is equality to dur.

## Structure
- Package tlc_pkg holds:
  - light code constants RED, AMBER, GREEN, DARK;
  - the state enum;
  - a function returning an all-red vector for NUM_DIR;
  - a one-hot sanitize function.
- Sub-module tlc_tick_gen: prescaler with parameter TICK_DIV and output tick. It is instantiated once.
- Phase table and FSM live in tlc_phase_sequencer.

## Test plan
- Reset with run=0: lights all 100 and state IDLE. Assert rst mid-RUN: all red on the next cycle, phase_idx 0.
- Program phases 0..5 with dur 7,2,5,5,3,2 and distinct patterns, TICK_DIV=1, then run=1: 2 cycles red, then phase 0 for 8 cycles, phase 1 for 3, and so on. phase_done pulses at each boundary; phase 5 wraps to phase 0.
- Write phase 2 while phase 2 is active: the current dwell is unchanged and the new value applies on the next lap. Write with cfg_addr=7: no effect.
- Pattern 011 on approach 1: lamp output 100 for that approach.
- flash=1 mid-phase with dur=5: the phase completes, then ALLRED_T red, then amber/dark toggling every FLASH_T ticks. Drop flash: CLEAR, then RUN phase 0.
- run=0 mid-phase: the phase completes, then CLEAR, then IDLE all red. With TICK_DIV=4, dur=1 lasts 8 cycles.
